// File: rtl/nalu_serial_if.sv
// Handshake and operand/result bundle for nalu_serial.
interface nalu_serial_if #(
    parameter int WIDTH = 16
);
    logic             RDY;
    logic             start;
    logic [3:0]       op;
    logic             BCD;
    logic [WIDTH-1:0] AI;
    logic [WIDTH-1:0] BI;
    logic             CI;
    logic [WIDTH-1:0] OUT;
    logic             CO;
    logic             V;
    logic             Z;
    logic             N;
    logic             HC;
    logic             busy;
    logic             done;

    modport master (
        output RDY, start, op, BCD, AI, BI, CI,
        input  OUT, CO, V, Z, N, HC, busy, done
    );

    modport slave (
        input  RDY, start, op, BCD, AI, BI, CI,
        output OUT, CO, V, Z, N, HC, busy, done
    );
endinterface

// File: rtl/nalu_serial.sv
// Digit-serial ALU: DPC nibbles per cycle, LSB first, start/busy/done handshake.
// Decimal correction for ADD/SUB is built only when NALU_BCD_EN is defined.

module nalu_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       a_up,
    input  logic       cin,
    input  logic [3:0] op,
    input  logic       bcd,
    output logic [3:0] r,
    output logic       cout
);
    logic [3:0] bop;
    logic [4:0] s;

`ifndef NALU_BCD_EN
    logic bcd_unused;
    assign bcd_unused = bcd;
`endif

    always_comb begin
        bop = 4'h0;
        if (op == 4'b0000)      bop = b;
        else if (op == 4'b0001) bop = ~b;
        else if (op == 4'b0010) bop = a;
        s    = {1'b0, a} + {1'b0, bop} + {4'b0, cin};
        r    = s[3:0];
        cout = s[4];
`ifdef NALU_BCD_EN
        if (bcd && op[3:1] == 3'b000) begin
            if (op[0]) begin
                if (!s[4]) r = s[3:0] + 4'd10;
            end else begin
                cout = (s >= 5'd10);
                if (cout) r = s[3:0] + 4'd6;
            end
        end
`endif
        // Non-adder ops replace the digit but keep the a+cin carry for HC.
        if (op[3]) begin
            r = a;
        end else begin
            case (op[2:0])
                3'b011:  r = {a_up, a[3:1]};
                3'b100:  r = a | b;
                3'b101:  r = a & b;
                3'b110:  r = a ^ b;
                3'b111:  r = a;
                default: ;
            endcase
        end
    end
endmodule

module nalu_serial #(
    parameter int WIDTH = 16,
    parameter int DPC   = 1
) (
    input logic         clk,
    input logic         reset,
    nalu_serial_if.slave bus
);
    localparam int G  = 4 * DPC;
    localparam int L  = WIDTH / G;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic [3:0] op;
        logic       bcd;
        logic       ci;
        logic       a_lsb;
        logic       a_msb;
        logic       bop_msb;
    } req_t;

    logic [1:0]            state;
    req_t                  req;
    logic [WIDTH:0]        a_sh;
    logic [WIDTH-1:0]      b_sh;
    logic [WIDTH-1:0]      r_sh;
    logic                  carry;
    logic                  hc_q;
    logic [CW-1:0]         cnt;
    logic [DPC:0]          c;
    logic [DPC-1:0][3:0]   r_dig;
    logic [WIDTH+G-1:0]    r_cat;
    logic                  bop_msb;
    logic                  arith_op;
    logic                  co_f;

    assign c[0] = carry;

    // a_sh carries CI above A so the last group's ROR fill bit is CI.
    for (genvar i = 0; i < DPC; i++) begin : g_dig
        nalu_digit u_dig (
            .a    (a_sh[4*i +: 4]),
            .b    (b_sh[4*i +: 4]),
            .a_up (a_sh[4*i+4]),
            .cin  (c[i]),
            .op   (req.op),
            .bcd  (req.bcd),
            .r    (r_dig[i]),
            .cout (c[i+1])
        );
    end

    assign r_cat    = {r_dig, r_sh};
    assign arith_op = (req.op[3:2] == 2'b00) && (req.op[1:0] != 2'b11);
    assign co_f     = arith_op ? carry : ((req.op == 4'b0011) ? req.a_lsb : req.ci);

    always_comb begin
        case (bus.op)
            4'b0000: bop_msb = bus.BI[WIDTH-1];
            4'b0001: bop_msb = ~bus.BI[WIDTH-1];
            4'b0010: bop_msb = bus.AI[WIDTH-1];
            default: bop_msb = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            req      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            carry    <= 1'b0;
            hc_q     <= 1'b0;
            cnt      <= '0;
            bus.OUT  <= '0;
            bus.CO   <= 1'b0;
            bus.V    <= 1'b0;
            bus.Z    <= 1'b0;
            bus.N    <= 1'b0;
            bus.HC   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (bus.RDY) begin
            case (state)
                S_IDLE: if (bus.start) begin
                    req      <= '{op: bus.op, bcd: bus.BCD, ci: bus.CI, a_lsb: bus.AI[0],
                                  a_msb: bus.AI[WIDTH-1], bop_msb: bop_msb};
                    a_sh     <= {bus.CI, bus.AI};
                    b_sh     <= bus.BI;
                    carry    <= bus.CI;
                    cnt      <= '0;
                    state    <= S_RUN;
                    bus.busy <= 1'b1;
                end
                S_RUN: begin
                    carry <= c[DPC];
                    a_sh  <= a_sh >> G;
                    b_sh  <= b_sh >> G;
                    r_sh  <= r_cat[WIDTH+G-1:G];
                    cnt   <= cnt + CW'(1);
                    if (cnt == '0) hc_q <= c[1];
                    if (cnt == CW'(L - 1)) begin
                        state    <= S_FIN;
                        bus.busy <= 1'b0;
                    end
                end
                S_FIN: begin
                    bus.OUT  <= r_sh;
                    bus.CO   <= co_f;
                    bus.N    <= r_sh[WIDTH-1];
                    bus.Z    <= ~|r_sh;
                    bus.V    <= req.a_msb ^ req.bop_msb ^ co_f ^ r_sh[WIDTH-1];
                    bus.HC   <= hc_q;
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end
                default: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nalu_serial.sv
// Directed bench for nalu_serial: DPC=1 and DPC=2 instances, expectations follow NALU_BCD_EN.
module tb_nalu_serial;
    logic clk = 1'b0;
    logic reset;
    logic rdy;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nalu_serial_if #(.WIDTH(16)) if0 ();
    nalu_serial_if #(.WIDTH(16)) if1 ();
    assign if0.RDY = rdy;
    assign if1.RDY = rdy;

    nalu_serial #(.WIDTH(16), .DPC(1)) u_dut  (.clk(clk), .reset(reset), .bus(if0));
    nalu_serial #(.WIDTH(16), .DPC(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if1));

    typedef struct {
        logic [3:0]  op;
        logic        bcd;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] eo;
        logic [4:0]  ef;   // {CO,V,Z,N,HC}
    } vec_t;

`ifdef NALU_BCD_EN
    localparam logic [15:0] E_A1 = 16'h1000; localparam logic [4:0] F_A1 = 5'b00001;
    localparam logic [15:0] E_A2 = 16'h0000; localparam logic [4:0] F_A2 = 5'b10101;
    localparam logic [15:0] E_S1 = 16'h0999; localparam logic [4:0] F_S1 = 5'b10000;
    localparam logic [15:0] E_S2 = 16'h9999; localparam logic [4:0] F_S2 = 5'b00010;
    localparam logic [15:0] E_A3 = 16'h0010; localparam logic [4:0] F_A3 = 5'b00001;
    localparam logic [15:0] E_D2 = 16'h5000; localparam logic [4:0] F_D2 = 5'b00001;
`else
    localparam logic [15:0] E_A1 = 16'h099A; localparam logic [4:0] F_A1 = 5'b00000;
    localparam logic [15:0] E_A2 = 16'h999A; localparam logic [4:0] F_A2 = 5'b00010;
    localparam logic [15:0] E_S1 = 16'h0FFF; localparam logic [4:0] F_S1 = 5'b10000;
    localparam logic [15:0] E_S2 = 16'hFFFF; localparam logic [4:0] F_S2 = 5'b00010;
    localparam logic [15:0] E_A3 = 16'h000A; localparam logic [4:0] F_A3 = 5'b00000;
    localparam logic [15:0] E_D2 = 16'h499A; localparam logic [4:0] F_D2 = 5'b00000;
`endif

    vec_t vt [14];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one operation and follows it until done (bounded); k counts edges after acceptance.
    task automatic run_op(input bit sel, input vec_t v, input int stall_at, input bit glitch,
                          output int busy_cyc, output int done_at);
        if (sel) begin
            if1.op = v.op; if1.BCD = v.bcd; if1.AI = v.a; if1.BI = v.b; if1.CI = v.ci; if1.start = 1'b1;
        end else begin
            if0.op = v.op; if0.BCD = v.bcd; if0.AI = v.a; if0.BI = v.b; if0.CI = v.ci; if0.start = 1'b1;
        end
        @(posedge clk); #1;
        if0.start = 1'b0; if1.start = 1'b0;
        busy_cyc = 0;
        done_at  = 99;
        for (int k = 0; k < 40 && done_at == 99; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (sel ? if1.busy : if0.busy) busy_cyc++;
            if (sel ? if1.done : if0.done) done_at = k;
            if (stall_at >= 0 && k == stall_at)     rdy = 1'b0;
            if (stall_at >= 0 && k == stall_at + 3) rdy = 1'b1;
            if (glitch && k == 2) begin if0.AI = 16'hFFFF; if0.BI = 16'hFFFF; if0.start = 1'b1; end
            if (glitch && k == 3) if0.start = 1'b0;
        end
        rdy = 1'b1;
    endtask

    task automatic tail_chk(input string tag);
        @(posedge clk); #1;
        chk({tag, " done_1cyc"}, {31'b0, if0.done}, 32'd0);
        chk({tag, " idle"}, {31'b0, if0.busy}, 32'd0);
    endtask

    initial begin
        int bc, da;
        vt[0]  = '{4'b0000, 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 5'b00001};
        vt[1]  = '{4'b0000, 1'b1, 16'h0999, 16'h0001, 1'b0, E_A1, F_A1};
        vt[2]  = '{4'b0000, 1'b1, 16'h9999, 16'h0001, 1'b0, E_A2, F_A2};
        vt[3]  = '{4'b0001, 1'b1, 16'h1000, 16'h0001, 1'b1, E_S1, F_S1};
        vt[4]  = '{4'b0001, 1'b1, 16'h0000, 16'h0001, 1'b1, E_S2, F_S2};
        vt[5]  = '{4'b0001, 1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 5'b11000};
        vt[6]  = '{4'b0011, 1'b0, 16'h8001, 16'h0000, 1'b1, 16'hC000, 5'b11010};
        vt[7]  = '{4'b0010, 1'b0, 16'h8001, 16'h0000, 1'b0, 16'h0002, 5'b11000};
        vt[8]  = '{4'b0101, 1'b0, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 5'b10000};
        vt[9]  = '{4'b0110, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 5'b00100};
        vt[10] = '{4'b0100, 1'b0, 16'h1200, 16'h0034, 1'b0, 16'h1234, 5'b00000};
        vt[11] = '{4'b1010, 1'b0, 16'h80F0, 16'h1111, 1'b0, 16'h80F0, 5'b00010};
        vt[12] = '{4'b0111, 1'b0, 16'h000F, 16'h1111, 1'b1, 16'h000F, 5'b11001};
        vt[13] = '{4'b0010, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'h000A, 5'b00000};

        reset = 1'b1; rdy = 1'b1;
        if0.start = 1'b0; if0.op = '0; if0.BCD = 1'b0; if0.AI = '0; if0.BI = '0; if0.CI = 1'b0;
        if1.start = 1'b0; if1.op = '0; if1.BCD = 1'b0; if1.AI = '0; if1.BI = '0; if1.CI = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out", {16'b0, if0.OUT}, 32'd0);
        chk("rst flags", {27'b0, if0.CO, if0.V, if0.Z, if0.N, if0.HC}, 32'd0);
        chk("rst busy_done", {30'b0, if0.busy, if0.done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op(1'b0, vt[i], -1, 1'b0, bc, da);
            chk($sformatf("v%0d out", i), {16'b0, if0.OUT}, {16'b0, vt[i].eo});
            chk($sformatf("v%0d flags", i), {27'b0, if0.CO, if0.V, if0.Z, if0.N, if0.HC}, {27'b0, vt[i].ef});
            chk($sformatf("v%0d busy_cyc", i), bc, 32'd4);
            chk($sformatf("v%0d done_at", i), da, 32'd5);
            tail_chk($sformatf("v%0d", i));
        end

        // Decimal-mode probe on a single digit.
        run_op(1'b0, '{4'b0000, 1'b1, 16'h0009, 16'h0001, 1'b0, 16'h0, 5'b0}, -1, 1'b0, bc, da);
        chk("bcd9p1 out", {16'b0, if0.OUT}, {16'b0, E_A3});
        chk("bcd9p1 flags", {27'b0, if0.CO, if0.V, if0.Z, if0.N, if0.HC}, {27'b0, F_A3});
        tail_chk("bcd9p1");

        // start pulsed while busy must not disturb the running op.
        run_op(1'b0, vt[0], -1, 1'b1, bc, da);
        chk("glitch out", {16'b0, if0.OUT}, 32'h2201);
        chk("glitch done_at", da, 32'd5);
        tail_chk("glitch");

        // RDY low for three edges mid-run delays done by three.
        run_op(1'b0, vt[5], 1, 1'b0, bc, da);
        chk("stall out", {16'b0, if0.OUT}, 32'h7FFF);
        chk("stall done_at", da, 32'd8);
        chk("stall busy_cyc", bc, 32'd7);
        tail_chk("stall");

        // Reset mid-run clears everything at once.
        if0.op = 4'b0000; if0.BCD = 1'b0; if0.AI = 16'h1234; if0.BI = 16'h0FCD; if0.CI = 1'b0;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst out", {16'b0, if0.OUT}, 32'd0);
        chk("midrst flags", {27'b0, if0.CO, if0.V, if0.Z, if0.N, if0.HC}, 32'd0);
        chk("midrst busy_done", {30'b0, if0.busy, if0.done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(1'b0, vt[0], -1, 1'b0, bc, da);
        chk("postrst out", {16'b0, if0.OUT}, 32'h2201);
        chk("postrst done_at", da, 32'd5);
        tail_chk("postrst");

        // Two digits per cycle.
        run_op(1'b1, '{4'b0000, 1'b1, 16'h4999, 16'h0001, 1'b0, 16'h0, 5'b0}, -1, 1'b0, bc, da);
        chk("dpc2 out", {16'b0, if1.OUT}, {16'b0, E_D2});
        chk("dpc2 flags", {27'b0, if1.CO, if1.V, if1.Z, if1.N, if1.HC}, {27'b0, F_D2});
        chk("dpc2 busy_cyc", bc, 32'd2);
        chk("dpc2 done_at", da, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
